// File: rtl/down_counter_if.sv
// Bundle of the down_counter control inputs and count/BCD outputs.
// master: the side that drives counting/load/load_val/max.
// slave: the counter itself.
interface down_counter_if #(
   parameter int DATA_SIZE = 5
);
   logic                 counting;
   logic                 load;
   logic [DATA_SIZE-1:0] load_val;
   logic [DATA_SIZE-1:0] max;
   logic [DATA_SIZE-1:0] ctr_out;
   logic                 zero;
   logic                 wrap;
   logic [3:0]           bcd_tens;
   logic [3:0]           bcd_ones;
   logic                 bcd_valid;
   logic [1:0]           dbg_state;   // converter FSM state, for checkers

   modport master (
      output counting, load, load_val, max,
      input  ctr_out, zero, wrap, bcd_tens, bcd_ones, bcd_valid, dbg_state
   );

   modport slave (
      input  counting, load, load_val, max,
      output ctr_out, zero, wrap, bcd_tens, bcd_ones, bcd_valid, dbg_state
   );
endinterface

// File: rtl/down_counter.sv
// Wrap-around down counter stepped by rising edges of a strobe, with
// synchronous preload and a one-bit-per-cycle double-dabble converter
// producing two BCD digits of the current count.
// Handshake: bcd_valid high means bcd_tens/bcd_ones describe ctr_out; any
// accepted load or strobe edge drops bcd_valid until a fresh conversion of
// the new count completes, and the digits hold their old values meanwhile.
module down_counter #(
   parameter int DATA_SIZE = 5
) (
   input logic          clk,
   input logic          rst_n,
   down_counter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   logic [DATA_SIZE-1:0] ctr;
   logic [DATA_SIZE-1:0] max_m1;
   logic [DATA_SIZE-1:0] load_eff;
   logic                 max_zero;
   logic                 counting_q;
   logic                 edge_det;
   logic                 update;
   logic                 wrap_q;
   logic                 start_req;

   state_t               state;
   state_t               state_nx;
   logic                 do_latch;
   logic                 do_shift;
   logic                 do_done;

   logic [DATA_SIZE-1:0] sh;
   logic [3:0]           tens;
   logic [3:0]           ones;
   logic [2:0]           bit_cnt;
   logic [3:0]           tens_adj;
   logic [3:0]           ones_adj;
   logic [DATA_SIZE+7:0] shifted;

   logic [3:0]           bcd_tens_q;
   logic [3:0]           bcd_ones_q;
   logic                 bcd_valid_q;

   // max-1 is only consumed when max is non-zero
   assign max_zero = (bus.max == '0);
   assign max_m1   = bus.max - DATA_SIZE'(1);
   assign load_eff = max_zero ? '0 :
                     ((bus.load_val > max_m1) ? max_m1 : bus.load_val);
   assign edge_det = bus.counting & ~counting_q;
   assign update   = bus.load | edge_det;

   // Counter, strobe history and wrap pulse; load beats a strobe edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr        <= '0;
         wrap_q     <= 1'b0;
         counting_q <= 1'b1;
      end else begin
         counting_q <= bus.counting;
         wrap_q     <= 1'b0;
         if (bus.load) begin
            ctr <= load_eff;
         end else if (edge_det && !max_zero) begin
            if (ctr == '0) begin
               ctr    <= max_m1;
               wrap_q <= 1'b1;
            end else begin
               ctr <= ctr - DATA_SIZE'(1);
            end
         end
      end
   end

   // Pending conversion request, raised by every update, consumed on latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_req <= 1'b0;
      end else if (update) begin
         start_req <= 1'b1;
      end else if (do_latch) begin
         start_req <= 1'b0;
      end
   end

   // Converter state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Converter next state; an update aborts any conversion in flight
   always_comb begin
      state_nx = state;
      if (update) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start_req) state_nx = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == 3'(DATA_SIZE - 1)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   // Converter control strobes, suppressed in a cycle that restarts it
   always_comb begin
      do_latch = (state == ST_IDLE) && start_req && !update;
      do_shift = (state == ST_SHIFT) && !update;
      do_done  = (state == ST_DONE) && !update;
   end

   // Double-dabble step: add 3 to any digit >= 5, then shift left one bit
   always_comb begin
      tens_adj = (tens >= 4'd5) ? tens + 4'd3 : tens;
      ones_adj = (ones >= 4'd5) ? ones + 4'd3 : ones;
      shifted  = {tens_adj, ones_adj, sh} << 1;
   end

   // Converter datapath: binary shift register plus BCD scratch digits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh      <= '0;
         tens    <= '0;
         ones    <= '0;
         bit_cnt <= '0;
      end else if (do_latch) begin
         sh      <= ctr;
         tens    <= '0;
         ones    <= '0;
         bit_cnt <= '0;
      end else if (do_shift) begin
         {tens, ones, sh} <= shifted;
         bit_cnt          <= bit_cnt + 3'd1;
      end
   end

   // Presented digits and valid flag; digits only change on a finished conversion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_tens_q  <= '0;
         bcd_ones_q  <= '0;
         bcd_valid_q <= 1'b1;
      end else if (update) begin
         bcd_valid_q <= 1'b0;
      end else if (do_done) begin
         bcd_tens_q  <= tens;
         bcd_ones_q  <= ones;
         bcd_valid_q <= 1'b1;
      end
   end

   assign bus.ctr_out   = ctr;
   assign bus.zero      = (ctr == '0);
   assign bus.wrap      = wrap_q;
   assign bus.bcd_tens  = bcd_tens_q;
   assign bus.bcd_ones  = bcd_ones_q;
   assign bus.bcd_valid = bcd_valid_q;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: reset check, a table of single-cycle vectors,
// hand-written BCD latency/restart sequences, then random stimulus against
// a behavioural model of the counter and its BCD display.
module tb_down_counter;
   localparam int DS  = 5;
   localparam int LAT = DS + 2;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   down_counter_if #(.DATA_SIZE(DS)) bus ();

   down_counter #(.DATA_SIZE(DS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model state
   int m_ctr;
   int m_wrap;
   int m_cq;
   int m_since;
   int m_tens;
   int m_ones;

   typedef struct {
      logic          ld;
      logic [DS-1:0] lv;
      logic [DS-1:0] mx;
      logic          cnt;
      logic [DS-1:0] exp_ctr;
      logic          exp_wrap;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input int ld, input int lv, input int mx,
                          input int cnt, input int ec, input int ew);
      vec_t v;
      v.ld       = ld[0];
      v.lv       = DS'(lv);
      v.mx       = DS'(mx);
      v.cnt      = cnt[0];
      v.exp_ctr  = DS'(ec);
      v.exp_wrap = ew[0];
      vq.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one clock edge worth of behaviour computed from the current inputs
   task automatic model_step(input int ld, input int lv, input int mx, input int cnt);
      int edge_seen;
      edge_seen = (cnt != 0) && (m_cq == 0);
      m_cq   = cnt;
      m_wrap = 0;
      if (ld != 0) begin
         if (mx == 0) m_ctr = 0;
         else m_ctr = (lv > mx - 1) ? mx - 1 : lv;
      end else if (edge_seen && mx != 0) begin
         if (m_ctr == 0) begin
            m_ctr  = mx - 1;
            m_wrap = 1;
         end else begin
            m_ctr = m_ctr - 1;
         end
      end
      if (ld != 0 || edge_seen) m_since = 0;
      else if (m_since < 1000) m_since++;
      if (m_since == LAT) begin
         m_tens = m_ctr / 10;
         m_ones = m_ctr % 10;
      end
   endtask

   // driver: advance one clock with the inputs currently on the bus
   task automatic tick();
      model_step(int'(bus.load), int'(bus.load_val), int'(bus.max), int'(bus.counting));
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_ctr"},   int'(bus.ctr_out),   m_ctr);
      check({tag, "_wrap"},  int'(bus.wrap),      m_wrap);
      check({tag, "_zero"},  int'(bus.zero),      int'(m_ctr == 0));
      check({tag, "_valid"}, int'(bus.bcd_valid), int'(m_since >= LAT));
      check({tag, "_tens"},  int'(bus.bcd_tens),  m_tens);
      check({tag, "_ones"},  int'(bus.bcd_ones),  m_ones);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_ctr = 0; m_wrap = 0; m_cq = 1; m_since = 1000; m_tens = 0; m_ones = 0;

      // stimulus table: {load, load_val, max, counting} -> {ctr_out, wrap}
      add_vec(0,  0, 20, 1,  0, 0);  // strobe held across reset: no edge
      add_vec(0,  0, 20, 0,  0, 0);
      add_vec(0,  0, 20, 1, 19, 1);  // wrap 0 -> max-1
      add_vec(0,  0, 20, 1, 19, 0);  // wrap lasts one cycle
      add_vec(1, 25, 20, 0, 19, 0);  // load clamped to max-1
      add_vec(1, 12, 20, 1, 12, 0);  // load drops the simultaneous edge
      add_vec(0,  0, 20, 1, 12, 0);
      add_vec(0,  0, 20, 0, 12, 0);
      add_vec(0,  0, 20, 1, 11, 0);
      add_vec(0,  0, 20, 0, 11, 0);
      add_vec(0,  0, 20, 1, 10, 0);
      add_vec(1,  0, 20, 0,  0, 0);
      add_vec(0,  0, 20, 1, 19, 1);
      add_vec(0,  0,  8, 0, 19, 0);  // max shrinks below count
      add_vec(0,  0,  8, 1, 18, 0);  // no clamp on decrement
      add_vec(1,  7,  8, 0,  7, 0);  // load_val == max-1 kept
      add_vec(1,  8,  8, 0,  7, 0);  // load_val == max clamped
      add_vec(1,  7,  0, 0,  0, 0);  // max 0 forces load to 0
      add_vec(0,  0,  0, 1,  0, 0);  // max 0: no wrap
      add_vec(0,  0,  0, 0,  0, 0);
      add_vec(0,  0,  0, 1,  0, 0);
      add_vec(0,  0,  1, 0,  0, 0);
      add_vec(0,  0,  1, 1,  0, 1);  // max 1: wrap 0 -> 0

      // reset with counting held high
      rst_n        = 1'b0;
      bus.counting = 1'b1;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.max      = DS'(20);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_ctr",   int'(bus.ctr_out),   0);
      check("rst_wrap",  int'(bus.wrap),      0);
      check("rst_zero",  int'(bus.zero),      1);
      check("rst_tens",  int'(bus.bcd_tens),  0);
      check("rst_ones",  int'(bus.bcd_ones),  0);
      check("rst_valid", int'(bus.bcd_valid), 1);

      // table-driven vectors
      foreach (vq[i]) begin
         bus.load     = vq[i].ld;
         bus.load_val = vq[i].lv;
         bus.max      = vq[i].mx;
         bus.counting = vq[i].cnt;
         tick();
         check($sformatf("vec%0d_ctr", i),  int'(bus.ctr_out), int'(vq[i].exp_ctr));
         check($sformatf("vec%0d_wrap", i), int'(bus.wrap),    int'(vq[i].exp_wrap));
         check($sformatf("vec%0d_zero", i), int'(bus.zero),    int'(vq[i].exp_ctr == '0));
      end

      // BCD latency: load 19, digits 1/9 valid exactly LAT edges later
      bus.max = DS'(20); bus.counting = 1'b0;
      bus.load = 1'b1; bus.load_val = DS'(19);
      tick();
      bus.load = 1'b0;
      check("lat_upd_valid", int'(bus.bcd_valid), 0);
      for (int k = 1; k <= LAT; k++) begin
         tick();
         check($sformatf("lat_valid_k%0d", k), int'(bus.bcd_valid), int'(k == LAT));
      end
      check("lat_tens", int'(bus.bcd_tens), 1);
      check("lat_ones", int'(bus.bcd_ones), 9);

      // restart: load 15, strobe edge two cycles later -> 14
      bus.load = 1'b1; bus.load_val = DS'(15);
      tick();
      bus.load = 1'b0;
      tick();
      tick();
      bus.counting = 1'b1;
      tick();
      bus.counting = 1'b0;
      check("rst2_ctr", int'(bus.ctr_out), 14);
      for (int k = 1; k <= LAT; k++) begin
         tick();
         check($sformatf("rst2_valid_k%0d", k), int'(bus.bcd_valid), int'(k == LAT));
         if (k < LAT) begin
            check($sformatf("rst2_hold_t%0d", k), int'(bus.bcd_tens), 1);
            check($sformatf("rst2_hold_o%0d", k), int'(bus.bcd_ones), 9);
         end
      end
      check("rst2_tens", int'(bus.bcd_tens), 1);
      check("rst2_ones", int'(bus.bcd_ones), 4);

      // three pulses spaced one cycle apart -> three decrements
      for (int p = 0; p < 3; p++) begin
         bus.counting = 1'b1; tick();
         bus.counting = 1'b0; tick();
      end
      check("pulse3_ctr", int'(bus.ctr_out), 11);

      // strobe held high ten cycles -> one decrement
      bus.counting = 1'b1;
      repeat (10) tick();
      check("held_ctr", int'(bus.ctr_out), 10);
      check_model("held");

      // randomized stimulus against the model, with quiet gaps for conversions
      for (int i = 0; i < 1500; i++) begin
         if ((i % 50) >= 38) begin
            bus.load = 1'b0;
         end else begin
            bus.load     = ($urandom_range(0, 11) == 0);
            bus.load_val = DS'($urandom_range(0, 31));
            bus.counting = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 39) == 0)
               bus.max = ($urandom_range(0, 7) == 0) ? '0 : DS'($urandom_range(1, 31));
         end
         tick();
         check_model($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
